// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall control unit and the ID-stage control mux.
package hazard_stall_unit_pkg;

    localparam int HSU_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        HSU_RUN      = 2'd0,
        HSU_FLUSH    = 2'd1,
        HSU_MEM_WAIT = 2'd2
    } hsuState_t;

    // ALUOp carried by the bubble control word that ID muxes in when holdControl is set.
    localparam logic [5:0] HSU_BUBBLE_ALUOP = 6'b010101;

endpackage

// File: rtl/hazard_stall_unit_load_use_cmp.sv
// Combinational load-use detector comparing the EX load destination with the ID sources.
module hazard_load_use_cmp
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W = HSU_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRt,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    output logic                  loadUse
);

    logic rdNonZero;
    logic rsMatch;
    logic rtMatch;

    // Register 0 is hardwired, so a load targeting it never produces a dependency.
    assign rdNonZero = (exRd != '0);
    assign rsMatch   = (exRd == idRs);
    assign rtMatch   = idUsesRt && (exRd == idRt);
    assign loadUse   = exMemRead && rdNonZero && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hold/flush sequencer: load-use stalls, post-branch flushes, memory freeze with watchdog.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = HSU_REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRt,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  branchTaken,
    input  logic                  memBusy,
    output logic                  holdControl,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  ifIdFlush,
    output logic                  idExFlush,
    output logic                  memTimeout
);

    localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX   = BUSY_W'(MEM_TIMEOUT);
    localparam logic [BUSY_W-1:0] BUSY_FIRST = BUSY_W'(1);
    localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam bit                FLUSH_MULTI = (FLUSH_CYCLES > 1);

    hsuState_t         state;
    hsuState_t         stateNext;
    logic [2:0]        flushCnt;
    logic [2:0]        flushCntNext;
    logic [BUSY_W-1:0] busyCnt;
    logic [BUSY_W-1:0] busyCntNext;
    logic              timeoutNext;

    logic              loadUse;
    logic              holdComb;
    logic              pcComb;
    logic              ifIdWrComb;
    logic              ifIdFlComb;
    logic              idExFlComb;

    function automatic logic [BUSY_W-1:0] busyInc(input logic [BUSY_W-1:0] cnt);
        return (cnt >= BUSY_MAX) ? BUSY_MAX : cnt + BUSY_FIRST;
    endfunction

    hazard_load_use_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) uLoadUse (
        .idRs      (idRs),
        .idRt      (idRt),
        .idUsesRt  (idUsesRt),
        .exMemRead (exMemRead),
        .exRd      (exRd),
        .loadUse   (loadUse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HSU_RUN;
            flushCnt   <= '0;
            busyCnt    <= '0;
            memTimeout <= 1'b0;
        end else begin
            state      <= stateNext;
            flushCnt   <= flushCntNext;
            busyCnt    <= busyCntNext;
            memTimeout <= timeoutNext;
        end
    end

    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        busyCntNext  = busyCnt;
        timeoutNext  = memTimeout;
        holdComb     = 1'b0;
        pcComb       = 1'b1;
        ifIdWrComb   = 1'b1;
        ifIdFlComb   = 1'b0;
        idExFlComb   = 1'b0;

        case (state)
            HSU_RUN: begin
                if (memBusy) begin
                    // Freeze wins; a coincident branch stays latched in EX and is seen again later.
                    pcComb      = 1'b0;
                    ifIdWrComb  = 1'b0;
                    stateNext   = HSU_MEM_WAIT;
                    busyCntNext = BUSY_FIRST;
                end else if (branchTaken) begin
                    holdComb   = 1'b1;
                    ifIdFlComb = 1'b1;
                    idExFlComb = 1'b1;
                    if (FLUSH_MULTI) begin
                        stateNext    = HSU_FLUSH;
                        flushCntNext = FLUSH_INIT;
                    end
                end else if (loadUse) begin
                    holdComb   = 1'b1;
                    pcComb     = 1'b0;
                    ifIdWrComb = 1'b0;
                end
            end

            HSU_FLUSH: begin
                // Flush outputs hold for the whole state; memBusy only redirects the next state
                // and leaves flushCnt untouched so the remaining bubbles resume after the wait.
                holdComb   = 1'b1;
                ifIdFlComb = 1'b1;
                if (memBusy) begin
                    stateNext   = HSU_MEM_WAIT;
                    busyCntNext = BUSY_FIRST;
                end else if (flushCnt <= 3'd1) begin
                    stateNext    = HSU_RUN;
                    flushCntNext = '0;
                end else begin
                    flushCntNext = flushCnt - 3'd1;
                end
            end

            HSU_MEM_WAIT: begin
                pcComb     = 1'b0;
                ifIdWrComb = 1'b0;
                if (memBusy) begin
                    busyCntNext = busyInc(busyCnt);
                    if (busyCnt == BUSY_MAX) begin
                        timeoutNext = 1'b1;
                    end
                end else begin
                    busyCntNext = '0;
                    stateNext   = (flushCnt != '0) ? HSU_FLUSH : HSU_RUN;
                end
            end

            default: begin
                stateNext = HSU_RUN;
            end
        endcase
    end

    // Reset forces the free-running values straight through, independent of the inputs.
    always_comb begin
        holdControl = holdComb   && !rst;
        pcWrite     = pcComb     || rst;
        ifIdWrite   = ifIdWrComb || rst;
        ifIdFlush   = ifIdFlComb && !rst;
        idExFlush   = idExFlComb && !rst;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors with hand-computed control words.
module tb_hazard_stall_unit;

    localparam int RW = 5;

    // Expected word order: {holdControl, pcWrite, ifIdWrite, ifIdFlush, idExFlush, memTimeout}
    localparam logic [5:0] E_RUN   = 6'b011000;
    localparam logic [5:0] E_STALL = 6'b100000;
    localparam logic [5:0] E_BR    = 6'b111110;
    localparam logic [5:0] E_FL    = 6'b111100;
    localparam logic [5:0] E_FRZ   = 6'b000000;
    localparam logic [5:0] E_TO    = 6'b000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] idRs = '0;
    logic [RW-1:0] idRt = '0;
    logic          idUsesRt = 1'b0;
    logic          exMemRead = 1'b0;
    logic [RW-1:0] exRd = '0;
    logic          branchTaken = 1'b0;
    logic          memBusy = 1'b0;
    logic          holdControl;
    logic          pcWrite;
    logic          ifIdWrite;
    logic          ifIdFlush;
    logic          idExFlush;
    logic          memTimeout;

    typedef struct {
        logic [5:0] val;
        string      name;
    } expEntry_t;

    expEntry_t expQ[$];
    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .REG_ADDR_W   (RW),
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .idRs        (idRs),
        .idRt        (idRt),
        .idUsesRt    (idUsesRt),
        .exMemRead   (exMemRead),
        .exRd        (exRd),
        .branchTaken (branchTaken),
        .memBusy     (memBusy),
        .holdControl (holdControl),
        .pcWrite     (pcWrite),
        .ifIdWrite   (ifIdWrite),
        .ifIdFlush   (ifIdFlush),
        .idExFlush   (idExFlush),
        .memTimeout  (memTimeout)
    );

    // Argument order: rst, idRs, idRt, idUsesRt, exMemRead, exRd, branchTaken, memBusy
    task automatic step(input logic r, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic ut, input logic mr, input logic [RW-1:0] rd,
                        input logic bt, input logic mb, input logic [5:0] e, input string nm);
        expEntry_t ent;
        @(posedge clk);
        #1;
        rst         = r;
        idRs        = rs;
        idRt        = rt;
        idUsesRt    = ut;
        exMemRead   = mr;
        exRd        = rd;
        branchTaken = bt;
        memBusy     = mb;
        ent.val     = e;
        ent.name    = nm;
        expQ.push_back(ent);
    endtask

    task automatic idle(input logic [5:0] e, input string nm);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic busy(input logic [5:0] e, input string nm);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, e, nm);
    endtask

    always @(negedge clk) begin
        expEntry_t  ent;
        logic [5:0] act;
        if (expQ.size() != 0) begin
            ent = expQ.pop_front();
            act = {holdControl, pcWrite, ifIdWrite, ifIdFlush, idExFlush, memTimeout};
            testsRun++;
            if (act !== ent.val) begin
                testsFailed++;
                $display("FAIL %s: got %b expected %b (hold,pc,ifw,iff,idf,to)",
                         ent.name, act, ent.val);
            end
        end
    end

    initial begin
        // Reset drives free-running outputs even with a load-use hazard on the inputs.
        step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_RUN, "reset_outputs");
        idle(E_RUN, "idle_after_reset");

        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_STALL, "load_use_rs");
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, E_RUN,   "after_stall");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, E_RUN,   "rd_zero_no_hazard");
        step(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, E_RUN,   "rt_unused_no_stall");
        step(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, E_STALL, "rt_used_stall");

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR, "branch_first");
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_FL, "flush_ignores_loaduse");
        idle(E_RUN, "flush_done");

        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, E_BR, "branch_beats_loaduse");
        idle(E_FL,  "branch_loaduse_flush2");
        idle(E_RUN, "branch_loaduse_done");

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR, "branch_before_wait");
        busy(E_FL, "flush_busy_rises");
        for (int i = 0; i < 3; i++) busy(E_FRZ, "wait_busy");
        idle(E_FRZ, "wait_exit");
        idle(E_FL,  "flush_resumed");
        idle(E_RUN, "run_after_resume");

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_FRZ, "busy_beats_branch");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_FRZ, "wait_exit_branch_held");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR,  "branch_reseen");
        idle(E_FL,  "branch_reseen_flush2");
        idle(E_RUN, "branch_reseen_done");

        for (int i = 0; i < 9; i++) busy(E_FRZ, "watchdog_pre");
        busy(E_FRZ | E_TO, "watchdog_set");
        idle(E_FRZ | E_TO, "watchdog_exit");
        idle(E_RUN | E_TO, "watchdog_sticky");

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR | E_TO, "branch_before_rst");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN, "rst_mid_flush");
        idle(E_RUN, "no_residual_flush");

        busy(E_FRZ, "busy_before_rst");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN, "rst_mid_wait");
        idle(E_RUN, "run_after_wait_rst");

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
